// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy states and helpers for stage skid registers.
package pipe_pkg;

  localparam int unsigned SKID_STATE_W = 2;
  localparam int unsigned SKID_COUNT_W = 2;

  // Occupancy of a two-entry stage register; encoding equals beats held.
  typedef enum logic [SKID_STATE_W-1:0] {
    SKID_EMPTY = 2'd0,
    SKID_HALF  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Number of beats held in a given state.
  function automatic logic [SKID_COUNT_W-1:0] skid_count(input skid_state_e s);
    logic [SKID_COUNT_W-1:0] c;
    case (s)
      SKID_HALF: c = SKID_COUNT_W'(1);
      SKID_FULL: c = SKID_COUNT_W'(2);
      default:   c = SKID_COUNT_W'(0);
    endcase
    return c;
  endfunction

  // Upstream may present a beat whenever the skid slot is free.
  function automatic logic skid_can_accept(input skid_state_e s);
    return (s != SKID_FULL);
  endfunction

  // Main register holds a beat in every state but EMPTY.
  function automatic logic skid_has_beat(input skid_state_e s);
    return (s != SKID_EMPTY);
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage register with skid buffer; all outputs come from flops.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 38,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SKID_COUNT_W-1:0] count
);

  skid_state_e             state_q;
  skid_state_e             state_d;
  logic [DATA_W-1:0]       main_q;
  logic [DATA_W-1:0]       skid_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [SKID_COUNT_W-1:0] count_q;

  logic accept;
  logic drain;
  logic main_ld;
  logic main_from_skid;
  logic skid_ld;

  // Handshakes use only registered ready/valid, so in_ready never sees out_ready.
  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // Next-state and register-load decode; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d = SKID_HALF;
          main_ld = 1'b1;
        end
      end
      SKID_HALF: begin
        case ({accept, drain})
          2'b10: begin
            state_d = SKID_FULL;
            skid_ld = 1'b1;
          end
          2'b01: begin
            state_d = SKID_EMPTY;
          end
          2'b11: begin
            state_d = SKID_HALF;
            main_ld = 1'b1;
          end
          default: begin
            state_d = SKID_HALF;
          end
        endcase
      end
      SKID_FULL: begin
        if (drain) begin
          state_d        = SKID_HALF;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
    if (flush) begin
      state_d        = SKID_EMPTY;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
    end
  end

  // State and status flops; status is precomputed from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SKID_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= SKID_COUNT_W'(0);
    end else begin
      state_q     <= state_d;
      in_ready_q  <= skid_can_accept(state_d);
      out_valid_q <= skid_has_beat(state_d);
      count_q     <= skid_count(state_d);
    end
  end

  // Main payload register feeding out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= RESET_DATA;
    end else if (main_ld) begin
      main_q <= main_from_skid ? skid_q : in_data;
    end
  end

  // Skid payload register; contents are don't-care until it is written.
  always_ff @(posedge clk) begin
    if (!rst && skid_ld) begin
      skid_q <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = count_q;

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Directed and queue-model checks for pipe_skid_reg.
module tb_pipe_skid_reg;

  localparam int unsigned DATA_W = 38;
  localparam logic [DATA_W-1:0] RST_VAL = '0;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        count;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_d;
  logic              acc;
  logic              drn;

  pipe_skid_reg #(.DATA_W(DATA_W), .RESET_DATA(RST_VAL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'(RST_VAL));

    // Single beat latency
    push(38'h0AB);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_data", 64'(out_data), 64'h0AB);
    chk("lat_count", 64'(count), 64'd1);
    chk("lat_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("lat_drain_valid", 64'(out_valid), 64'd0);

    // Backpressure fills skid
    push(38'h1);
    push(38'h2);
    chk("bp_count", 64'(count), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_data", 64'(out_data), 64'h1);
    tick();
    chk("bp_stall_data", 64'(out_data), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("bp_first_out", 64'(out_data), 64'h2);
    chk("bp_first_count", 64'(count), 64'd1);
    tick();
    chk("bp_empty_valid", 64'(out_valid), 64'd0);
    chk("bp_empty_count", 64'(count), 64'd0);

    // Streaming, one beat per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DATA_W'(i);
      tick();
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 64'(out_valid), 64'd0);

    // Flush in FULL with an incoming beat
    out_ready = 1'b0;
    push(38'h11);
    push(38'h22);
    chk("fl_pre_count", 64'(count), 64'd2);
    flush = 1'b1; in_valid = 1'b1; in_data = 38'h3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    push(38'h44);
    chk("fl_next_data", 64'(out_data), 64'h44);
    out_ready = 1'b1;
    tick();
    chk("fl_next_empty", 64'(out_valid), 64'd0);
    chk("fl_next_count", 64'(count), 64'd0);

    // in_ready must not react to out_ready inside a cycle
    out_ready = 1'b0;
    push(38'h55);
    push(38'h66);
    chk("comb_ready_lo", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("comb_ready_hi", 64'(in_ready), 64'd0);

    // Reset in FULL while draining
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_out_valid", 64'(out_valid), 64'd0);
    chk("rf_out_data", 64'(out_data), 64'(RST_VAL));
    chk("rf_count", 64'(count), 64'd0);
    chk("rf_in_ready", 64'(in_ready), 64'd1);

    // Reset with flush, both high
    out_ready = 1'b0;
    push(38'h77);
    push(38'h88);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 38'h99;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rff_out_valid", 64'(out_valid), 64'd0);
    chk("rff_out_data", 64'(out_data), 64'(RST_VAL));
    chk("rff_count", 64'(count), 64'd0);

    // Random traffic against a queue model
    model_q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = DATA_W'({$urandom, $urandom});
      chk("rnd_in_ready", 64'(in_ready), 64'(model_q.size() < 2));
      chk("rnd_count", 64'(count), 64'(model_q.size()));
      acc = in_valid & in_ready;
      drn = out_valid & out_ready;
      if (drn) begin
        if (model_q.size() == 0) begin
          chk("rnd_spurious", 64'(out_valid), 64'd0);
        end else begin
          exp_d = model_q.pop_front();
          chk("rnd_order", 64'(out_data), 64'(exp_d));
        end
      end
      if (acc) model_q.push_back(in_data);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_skid_reg

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 38, payload width in bits (16 mem data + 16 alu result + 4 rd + ret + mem_to_reg).
REQ-002 Parameter RESET_DATA, default 0, value loaded into the output payload register on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  upstream stage presents a beat.
REQ-006 in_ready  output  1  block can accept a beat this cycle; registered.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 flush  input  1  discard all held beats and any incoming beat this cycle.
REQ-009 out_valid  output  1  out_data holds a valid beat.
REQ-010 out_ready  input  1  downstream consumes the beat this cycle.
REQ-011 out_data  output  DATA_W  payload of the oldest held beat.
REQ-012 count  output  2  number of beats held (0, 1 or 2).

Function
REQ-013 Accept = in_valid & in_ready; drain = out_valid & out_ready; both evaluated on the same edge.
REQ-014 Storage: one main register driving out_data and one skid register; state machine EMPTY (0 beats), HALF (main valid), FULL (main and skid valid).
REQ-015 EMPTY: accept -> HALF, main <= in_data; otherwise stay EMPTY.
REQ-016 HALF: accept without drain -> FULL, skid <= in_data; drain without accept -> EMPTY; accept and drain together -> HALF, main <= in_data; neither -> HALF, hold.
REQ-017 FULL: drain -> HALF, main <= skid; otherwise hold; no accept is possible because in_ready is 0.
REQ-018 in_ready SHALL be 1 in EMPTY and HALF and 0 in FULL, and SHALL be a register output with no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 in HALF and FULL; count SHALL be 0/1/2 for EMPTY/HALF/FULL.
REQ-020 Latency: a beat accepted at edge N SHALL appear on out_data with out_valid=1 after edge N when the block was EMPTY.
REQ-021 Beats SHALL leave in acceptance order; no beat SHALL be duplicated or dropped except by flush or reset.
REQ-022 With out_ready held at 1 and in_valid held at 1, throughput SHALL be one beat per cycle with the state remaining in HALF.
REQ-023 Flush SHALL force EMPTY on the next edge, override accept and drain in the same cycle, and leave the main and skid registers unchanged.
REQ-024 out_data SHALL be unchanged while out_valid=1 and out_ready=0.

Reset
REQ-025 rst SHALL take priority over flush and all handshakes.
REQ-026 After reset: state EMPTY, in_ready=1, out_valid=0, count=0, out_data=RESET_DATA; the skid register needs no reset value.
REQ-027 Reset asserted mid-transfer SHALL discard held beats, with no partial update on that edge.

Structure
REQ-028 The state enum (EMPTY, HALF, FULL) SHALL live in the shared pipeline package pipe_pkg, for reuse by other stage registers.
REQ-029 The block SHALL be a single module with no sub-modules; MEM/WB and the other stages instantiate it with their own DATA_W.

Verification
REQ-030 Reset, then in_valid=1 with in_data=0x0AB at edge 1, out_ready=0 -> after edge 1, out_valid=1, out_data=0x0AB, count=1, in_ready=1.
REQ-031 Backpressure: beats 0x1 and 0x2 sent with out_ready=0 -> count=2, in_ready=0; out_ready=1 -> out_data 0x1 then 0x2, then out_valid=0.
REQ-032 Streaming: in_valid=out_ready=1 for 10 cycles with data 0..9 -> out_data shows 0..9 consecutively, one per cycle, count stays 1.
REQ-033 Flush in FULL together with in_valid=1 and data 0x3 -> next cycle count=0, out_valid=0, in_ready=1; 0x3 never appears on out_data.
REQ-034 rst=1 in FULL while out_ready=1 -> next cycle out_valid=0, out_data=RESET_DATA; rst with flush both high -> same result.
REQ-035 Random in_valid/out_ready for 10k cycles against a queue model -> order matches, no loss or duplicate, in_ready never depends combinationally on out_ready.
